// File: rtl/fc_dispatch_ctrl_if.sv
// Handshake bundle between the FC dispatcher, its command/response client and the FC unit.
// The master modport is the dispatcher's view; slave is the environment (host plus FC unit).
interface fc_dispatch_ctrl_if #(
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_input_ptr;
    logic [31:0]      cmd_weights_ptr;
    logic [31:0]      cmd_bias_ptr;
    logic [31:0]      cmd_output_ptr;
    logic [31:0]      cmd_dims;
    logic [TAG_W-1:0] cmd_tag;

    logic             fc_start;
    logic [31:0]      fc_input_ptr;
    logic [31:0]      fc_weights_ptr;
    logic [31:0]      fc_bias_ptr;
    logic [31:0]      fc_output_ptr;
    logic [31:0]      fc_dims;
    logic             fc_ready;
    logic             fc_done;
    logic [31:0]      fc_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    modport master (
        input  cmd_valid, cmd_input_ptr, cmd_weights_ptr, cmd_bias_ptr, cmd_output_ptr,
               cmd_dims, cmd_tag,
        output cmd_ready,
        output fc_start, fc_input_ptr, fc_weights_ptr, fc_bias_ptr, fc_output_ptr, fc_dims,
        input  fc_ready, fc_done, fc_result,
        output rsp_valid, rsp_result, rsp_tag, rsp_err,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_input_ptr, cmd_weights_ptr, cmd_bias_ptr, cmd_output_ptr,
               cmd_dims, cmd_tag,
        input  cmd_ready,
        input  fc_start, fc_input_ptr, fc_weights_ptr, fc_bias_ptr, fc_output_ptr, fc_dims,
        output fc_ready, fc_done, fc_result,
        input  rsp_valid, rsp_result, rsp_tag, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/fc_dispatch_ctrl.sv
// FC dispatcher: queues layer descriptors, issues one at a time, returns result/tag/err (watchdog: FC_DISPATCH_TIMEOUT_EN).
// Latency: accept -> fc_start one cycle later when idle; fc_done -> rsp_valid the following cycle.
// Backpressure: cmd_ready drops while the FIFO is full; rsp_* held until rsp_ready.
module fc_dispatch_ctrl #(
    parameter int DEPTH          = 4,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    fc_dispatch_ctrl_if.master  bus,
    output logic                busy,
    output logic [15:0]         done_count
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0]      input_ptr;
        logic [31:0]      weights_ptr;
        logic [31:0]      bias_ptr;
        logic [31:0]      output_ptr;
        logic [31:0]      dims;
        logic [TAG_W-1:0] tag;
    } desc_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    desc_t            fifo_mem [DEPTH];
    desc_t            cmd_dat;
    desc_t            head_dat;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;
    logic             head_vld;
    logic             head_bad;
    logic             done_hit;
    logic             timeout_hit;
    logic [TAG_W-1:0] cur_tag;

    assign cmd_dat = '{
        input_ptr:   bus.cmd_input_ptr,
        weights_ptr: bus.cmd_weights_ptr,
        bias_ptr:    bus.cmd_bias_ptr,
        output_ptr:  bus.cmd_output_ptr,
        dims:        bus.cmd_dims,
        tag:         bus.cmd_tag
    };

    assign bus.cmd_ready = (count < FULL_CNT);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign head_dat      = fifo_mem[rd_ptr];
    assign head_vld      = (count != '0);
    // A zero-sized layer is answered locally with an error, never sent to the FC unit.
    assign head_bad      = (head_dat.dims[31:16] == 16'd0) || (head_dat.dims[15:0] == 16'd0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FC_DISPATCH_TIMEOUT_EN
    logic [31:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 32'd1;
        end
    end

    // fc_done in the same cycle as expiry still wins.
    assign timeout_hit = (state == WAIT) && !bus.fc_done &&
                         (wait_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    assign done_hit = (state == WAIT) && bus.fc_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (head_vld) begin
                    if (head_bad) begin
                        pop       = 1'b1;
                        state_nxt = RESP;
                    end else if (bus.fc_ready) begin
                        pop       = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (done_hit || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.fc_start  = (state == ISSUE);
    assign bus.rsp_valid = (state == RESP);
    assign busy          = (state != IDLE) || head_vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.fc_input_ptr   <= '0;
            bus.fc_weights_ptr <= '0;
            bus.fc_bias_ptr    <= '0;
            bus.fc_output_ptr  <= '0;
            bus.fc_dims        <= '0;
            cur_tag            <= '0;
            bus.rsp_result     <= '0;
            bus.rsp_tag        <= '0;
            bus.rsp_err        <= 1'b0;
            done_count         <= '0;
        end else begin
            if (pop && !head_bad) begin
                bus.fc_input_ptr   <= head_dat.input_ptr;
                bus.fc_weights_ptr <= head_dat.weights_ptr;
                bus.fc_bias_ptr    <= head_dat.bias_ptr;
                bus.fc_output_ptr  <= head_dat.output_ptr;
                bus.fc_dims        <= head_dat.dims;
                cur_tag            <= head_dat.tag;
            end
            if (pop && head_bad) begin
                bus.rsp_result <= '0;
                bus.rsp_tag    <= head_dat.tag;
                bus.rsp_err    <= 1'b1;
            end
            if (done_hit) begin
                bus.rsp_result <= bus.fc_result;
                bus.rsp_tag    <= cur_tag;
                bus.rsp_err    <= 1'b0;
            end else if (timeout_hit) begin
                bus.rsp_result <= '0;
                bus.rsp_tag    <= cur_tag;
                bus.rsp_err    <= 1'b1;
            end
            if (state == RESP && bus.rsp_ready) begin
                done_count <= done_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_fc_dispatch_ctrl.sv
// Scoreboard bench for fc_dispatch_ctrl: behavioural FC unit plus an expected-response queue.
`timescale 1ns/1ps
module tb_fc_dispatch_ctrl;
    localparam int DEPTH          = 4;
    localparam int TAG_W          = 4;
    localparam int TIMEOUT_CYCLES = 16;

    typedef struct {
        logic [31:0]      result;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [15:0] done_count;

    fc_dispatch_ctrl_if #(.TAG_W(TAG_W)) bus ();

    fc_dispatch_ctrl #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .done_count(done_count)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   n_start = 0;
    int   start_cyc = 0;
    int   n_rsp = 0;
    int   rsp_cyc = 0;
    int   push_cyc = 0;
    int   done_cyc = 0;
    logic prev_rsp_vld = 1'b0;
    logic fc_auto = 1'b1;
    logic fixed_res = 1'b0;
    int   fc_lat = 3;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] fc_func(input logic [31:0] ip, wp, bp, op, dims);
        return ip ^ (wp << 1) ^ (bp << 2) ^ (op << 3) ^ dims;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.fc_start === 1'b1) begin
            n_start++;
            start_cyc = cyc;
        end
        if (bus.rsp_valid === 1'b1 && !prev_rsp_vld) rsp_cyc = cyc;
        prev_rsp_vld = (bus.rsp_valid === 1'b1);
        if (rst_n && bus.rsp_valid === 1'b1 && bus.rsp_ready) begin
            n_rsp++;
            check_eq("rsp_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check_eq("rsp_result", bus.rsp_result, mon_e.result);
                check_eq("rsp_tag", bus.rsp_tag, mon_e.tag);
                check_eq("rsp_err", bus.rsp_err, mon_e.err);
            end
        end
    end

    // Behavioural FC unit: answers each start after fc_lat cycles.
    initial begin
        logic [31:0] res;
        bus.fc_done   = 1'b0;
        bus.fc_result = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.fc_start === 1'b1 && fc_auto) begin
                res = fixed_res ? 32'h1234 :
                      fc_func(bus.fc_input_ptr, bus.fc_weights_ptr, bus.fc_bias_ptr,
                              bus.fc_output_ptr, bus.fc_dims);
                repeat (fc_lat) @(posedge clk);
                #1;
                bus.fc_done   = 1'b1;
                bus.fc_result = res;
                done_cyc      = cyc;
                @(posedge clk);
                #1;
                bus.fc_done   = 1'b0;
                bus.fc_result = '0;
            end
        end
    end

    task automatic push(input logic [31:0] dims, input logic [TAG_W-1:0] tag,
                        input bit to_err = 1'b0);
        logic [31:0] ip, wp, bp, op;
        exp_t e;
        bit   ok;
        ip = $urandom; wp = $urandom; bp = $urandom; op = $urandom;
        ok = 1'b0;
        bus.cmd_valid       = 1'b1;
        bus.cmd_input_ptr   = ip;
        bus.cmd_weights_ptr = wp;
        bus.cmd_bias_ptr    = bp;
        bus.cmd_output_ptr  = op;
        bus.cmd_dims        = dims;
        bus.cmd_tag         = tag;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = bus.cmd_ready;
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        check_eq("cmd_accept", ok, 1);
        push_cyc = cyc;
        e.tag = tag;
        if (dims[31:16] == 16'd0 || dims[15:0] == 16'd0 || to_err) begin
            e.result = '0;
            e.err    = 1'b1;
        end else begin
            e.result = fixed_res ? 32'h1234 : fc_func(ip, wp, bp, op, dims);
            e.err    = 1'b0;
        end
        if (ok) exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int i = 0;
        while ((busy || exp_q.size() != 0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        check_eq({tag, "_drained"}, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_fc_start"}, bus.fc_start, 0);
        check_eq({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check_eq({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done_count"}, done_count, 0);
        check_eq({tag, "_rsp_fields"}, {bus.rsp_result, bus.rsp_tag, bus.rsp_err}, 0);
        check_eq({tag, "_fc_bus"}, {bus.fc_input_ptr, bus.fc_dims}, 0);
    endtask

    function automatic logic [31:0] ok_dims();
        return {16'($urandom_range(1, 255)), 16'($urandom_range(1, 255))};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0, i;
        bus.cmd_valid = 1'b0; bus.cmd_input_ptr = '0; bus.cmd_weights_ptr = '0;
        bus.cmd_bias_ptr = '0; bus.cmd_output_ptr = '0; bus.cmd_dims = '0; bus.cmd_tag = '0;
        bus.fc_ready = 1'b1;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single command with a fixed result word.
        fixed_res = 1'b1; fc_lat = 10; s0 = n_start;
        push(32'h0004_0002, 4'd3);
        wait_idle("single", 100);
        check_eq("single_starts", n_start - s0, 1);
        check_eq("single_start_latency", start_cyc - push_cyc, 1);
        check_eq("single_rsp_latency", rsp_cyc - done_cyc, 1);
        check_eq("single_fc_dims", bus.fc_dims, 32'h0004_0002);
        check_eq("single_done_count", done_count, 1);
        fixed_res = 1'b0;

        // Fill the FIFO with the FC unit stalled, then a fifth push waits for space.
        bus.fc_ready = 1'b0; fc_lat = 3; s0 = n_start;
        for (int t = 0; t < 4; t++) push(ok_dims(), TAG_W'(t));
        @(negedge clk);
        check_eq("bp_full_cmd_ready", bus.cmd_ready, 0);
        check_eq("bp_full_busy", busy, 1);
        @(posedge clk); #1;
        fork
            push(ok_dims(), 4'd4);
            begin
                repeat (6) @(negedge clk);
                check_eq("bp_no_start_while_stalled", n_start - s0, 0);
                bus.fc_ready = 1'b1;
            end
        join
        wait_idle("bp", 300);
        check_eq("bp_starts", n_start - s0, 5);
        check_eq("bp_done_count", done_count, 6);

        // Zero-sized layers are rejected even with the FC unit not ready.
        bus.fc_ready = 1'b0; s0 = n_start;
        push(32'h0000_0010, 4'd7);
        push(32'h0010_0000, 4'd8);
        wait_idle("bad", 50);
        check_eq("bad_no_start", n_start - s0, 0);
        check_eq("bad_done_count", done_count, 8);
        bus.fc_ready = 1'b1;

        // Response held off: fields stay put and nothing else is issued.
        bus.rsp_ready = 1'b0; s0 = n_start;
        push(ok_dims(), 4'd9);
        push(ok_dims(), 4'd10);
        i = 0;
        while (bus.rsp_valid !== 1'b1 && i < 100) begin
            @(negedge clk);
            i++;
        end
        check_eq("held_rsp_valid", bus.rsp_valid, 1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_eq("held_rsp_stable", {bus.rsp_valid, bus.rsp_result, bus.rsp_tag, bus.rsp_err},
                     {1'b1, exp_q[0].result, exp_q[0].tag, exp_q[0].err});
        end
        check_eq("held_single_start", n_start - s0, 1);
        check_eq("held_done_count", done_count, 8);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        wait_idle("held", 100);
        check_eq("held_done_count_after", done_count, 10);

        // Reset while the FC unit is still working: the in-flight job is dropped.
        fc_lat = 30;
        push(ok_dims(), 4'd11);
        repeat (5) @(posedge clk);
        #1;
        check_eq("rstwait_busy", busy, 1);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rstwait");
        r0 = n_rsp;
        repeat (40) @(negedge clk);
        check_eq("rstwait_no_rsp", n_rsp - r0, 0);
        check_eq("rstwait_rsp_valid", bus.rsp_valid, 0);
        @(posedge clk); #1;
        fc_lat = 2;
        push(ok_dims(), 4'd12);
        wait_idle("recover", 100);
        check_eq("recover_done_count", done_count, 1);

`ifdef FC_DISPATCH_TIMEOUT_EN
        // No fc_done: the watchdog answers with an error after TIMEOUT_CYCLES of WAIT.
        fc_auto = 1'b0;
        push(ok_dims(), 4'd13, 1'b1);
        wait_idle("timeout", 100);
        check_eq("timeout_latency", rsp_cyc - start_cyc, TIMEOUT_CYCLES + 1);
        r0 = n_rsp;
        bus.fc_done = 1'b1; bus.fc_result = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.fc_done = 1'b0; bus.fc_result = '0;
        repeat (10) @(negedge clk);
        check_eq("timeout_late_done_ignored", n_rsp - r0, 0);
        check_eq("timeout_done_count", done_count, 2);
        fc_auto = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
